branch_driver: RTL and testbench

Initiator side of the predictor protocol: buffers a stream of resolved branch outcomes and, for each one, issues a `request` to the predictor, captures the returned `prediction`, then reports the actual outcome with `result`/`taken`. Prediction accuracy is scored in saturating counters. Sits between the trace/execute source and `predictor`, and drives the predictor's `request`, `result` and `taken` inputs directly.

---
 rtl/branch_driver.sv | 162 ++++++++++++++++
 tb/tb_branch_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_driver.sv
// branch_driver: initiator side of the predictor protocol.
// Buffers resolved branch outcomes in a small FIFO and, for each one, runs a
// REQ / WAIT / RES handshake with the predictor, then scores the prediction.
// Optional feature macro: BRANCH_DRIVER_STREAK_EN adds the max_streak output,
// which reports the longest run of consecutive mispredictions.
module branch_driver #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_taken,
  output logic             in_ready,
  output logic             request,
  output logic             result,
  output logic             taken,
  input  logic             prediction,
  output logic             mispredict,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] miss_count
`ifdef BRANCH_DRIVER_STREAK_EN
  ,
  output logic [CNT_W-1:0] max_streak
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RES} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic             pred_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] branchCount_q, missCount_q;

  logic push, pop, head, miss;

  assign push = in_valid && in_ready;
  assign pop  = (state_q == RES);
  assign head = mem_q[rdPtr_q];
  assign miss = pred_q != head;

  // FIFO occupancy after this edge; a simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Outcome storage; no reset needed since only entries below count are read
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= in_taken;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: IDLE looks at the registered count so a push never overlaps REQ entry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    state_d = RES;
      RES:     state_d = (count_d != '0) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Protocol outputs decoded purely from registered state
  always_comb begin
    request = 1'b0;
    result  = 1'b0;
    taken   = 1'b0;
    case (state_q)
      REQ:     request = 1'b1;
      RES:     begin
                 result = 1'b1;
                 taken  = head;
               end
      default: ;
    endcase
  end

  // Prediction capture in WAIT, scoring and saturating counters at RES
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_q        <= 1'b0;
      mispredict_q  <= 1'b0;
      branchCount_q <= '0;
      missCount_q   <= '0;
    end else begin
      mispredict_q <= 1'b0;
      if (state_q == WAIT) pred_q <= prediction;
      if (state_q == RES) begin
        if (branchCount_q != '1) branchCount_q <= branchCount_q + 1'b1;
        if (miss) begin
          mispredict_q <= 1'b1;
          if (missCount_q != '1) missCount_q <= missCount_q + 1'b1;
        end
      end
    end
  end

  assign in_ready     = (count_q != FULL_CNT);
  assign busy         = (state_q != IDLE) || (count_q != '0);
  assign mispredict   = mispredict_q;
  assign branch_count = branchCount_q;
  assign miss_count   = missCount_q;

`ifdef BRANCH_DRIVER_STREAK_EN
  logic [CNT_W-1:0] curRun_q, curRun_d, maxRun_q;

  // Current run grows on a miss and clears on a correct prediction
  always_comb begin
    curRun_d = curRun_q;
    if (state_q == RES) begin
      if (!miss)                curRun_d = '0;
      else if (curRun_q != '1)  curRun_d = curRun_q + 1'b1;
    end
  end

  // Streak registers; the longest run follows the updated current run at the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curRun_q <= '0;
      maxRun_q <= '0;
    end else begin
      curRun_q <= curRun_d;
      if (curRun_d > maxRun_q) maxRun_q <= curRun_d;
    end
  end

  assign max_streak = maxRun_q;
`endif

endmodule

// File: tb/tb_branch_driver.sv
// Self-checking bench for branch_driver. Two instances share one stimulus
// stream: the default 16-bit counters and a 2-bit variant for saturation.
// A transaction-level model (outcome queue, branch phase, unbounded tallies)
// predicts every output each cycle.
module tb_branch_driver;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_taken, prediction;
  logic in_ready, request, result, taken, mispredict, busy;
  logic [15:0] branch_count, miss_count;
  logic in_ready2, request2, result2, taken2, mispredict2, busy2;
  logic [1:0] branch_count2, miss_count2;
`ifdef BRANCH_DRIVER_STREAK_EN
  logic [15:0] max_streak;
  logic [1:0]  max_streak2;
`endif

  branch_driver #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_taken(in_taken),
    .in_ready(in_ready), .request(request), .result(result), .taken(taken),
    .prediction(prediction), .mispredict(mispredict), .busy(busy),
    .branch_count(branch_count), .miss_count(miss_count)
`ifdef BRANCH_DRIVER_STREAK_EN
    , .max_streak(max_streak)
`endif
  );

  branch_driver #(.DEPTH(DEPTH), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_taken(in_taken),
    .in_ready(in_ready2), .request(request2), .result(result2), .taken(taken2),
    .prediction(prediction), .mispredict(mispredict2), .busy(busy2),
    .branch_count(branch_count2), .miss_count(miss_count2)
`ifdef BRANCH_DRIVER_STREAK_EN
    , .max_streak(max_streak2)
`endif
  );

  // Reference model state
  bit     q[$];
  int     phase;
  bit     predM;
  bit     mispM;
  longint rawBranch, rawMiss, curRun, maxRun;
  bit     modelValid = 1'b0;

  int errors = 0;
  int checks = 0;
  int pulseCount = 0;
  bit sawNotReady = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Compare both instances against the model for the current cycle
  task automatic checkAll();
    bit expTaken;
    if (!modelValid) return;
    expTaken = (phase == 3) ? q[0] : 1'b0;
    if (mispredict === 1'b1) pulseCount++;
    if (in_ready === 1'b0) sawNotReady = 1'b1;
    checkOutput("in_ready",     in_ready,     q.size() < DEPTH);
    checkOutput("request",      request,      phase == 1);
    checkOutput("result",       result,       phase == 3);
    checkOutput("taken",        taken,        expTaken);
    checkOutput("mispredict",   mispredict,   mispM);
    checkOutput("busy",         busy,         (phase != 0) || (q.size() != 0));
    checkOutput("branch_count", branch_count, sat(rawBranch, 16));
    checkOutput("miss_count",   miss_count,   sat(rawMiss, 16));
    checkOutput("request2",     request2,     phase == 1);
    checkOutput("result2",      result2,      phase == 3);
    checkOutput("taken2",       taken2,       expTaken);
    checkOutput("branch_count2", branch_count2, sat(rawBranch, 2));
    checkOutput("miss_count2",  miss_count2,  sat(rawMiss, 2));
`ifdef BRANCH_DRIVER_STREAK_EN
    checkOutput("max_streak",   max_streak,   sat(maxRun, 16));
    checkOutput("max_streak2",  max_streak2,  sat(maxRun, 2));
`endif
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic updateModel();
    int  oldSize, nxt;
    bit  head;
    if (!rst_n) begin
      q.delete();
      phase = 0; predM = 0; mispM = 0;
      rawBranch = 0; rawMiss = 0; curRun = 0; maxRun = 0;
      modelValid = 1'b1;
      return;
    end
    if (!modelValid) return;
    oldSize = q.size();
    mispM = 1'b0;
    nxt = 0;
    case (phase)
      0: nxt = (oldSize != 0) ? 1 : 0;
      1: nxt = 2;
      2: begin nxt = 3; predM = prediction; end
      default: begin
        head = q.pop_front();
        rawBranch++;
        if (predM != head) begin
          rawMiss++;
          mispM = 1'b1;
          curRun++;
          if (curRun > maxRun) maxRun = curRun;
        end else begin
          curRun = 0;
        end
      end
    endcase
    if (in_valid && oldSize < DEPTH) q.push_back(in_taken);
    if (phase == 3) nxt = (q.size() != 0) ? 1 : 0;
    phase = nxt;
  endtask

  // One clock cycle: check outputs, drive inputs, then step the model at the edge
  task automatic applyStimulus(input bit v, input bit t, input bit p, input bit r);
    @(negedge clk);
    checkAll();
    in_valid = v; in_taken = t; prediction = p; rst_n = r;
    @(posedge clk);
    updateModel();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
  endtask

  // Idle until the model says everything has drained, with a cycle budget
  task automatic drain(input bit p);
    int n;
    n = 0;
    while ((phase != 0 || q.size() != 0) && n < 100) begin
      applyStimulus(0, 0, p, 1);
      n++;
    end
    checkOutput("drainTimeout", n < 100, 1);
    applyStimulus(0, 0, p, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_taken = 1'b0; prediction = 1'b0;

    $display("[TB] reset");
    doReset();

    $display("[TB] single branch");
    applyStimulus(1, 1, 1, 1);
    drain(1);
    checkOutput("singleBranches", branch_count, 1);
    checkOutput("singleMisses",   miss_count,   0);

    $display("[TB] mispredict and streak");
    doReset();
    pulseCount = 0;
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 0, 0, 1);
    drain(0);
    checkOutput("streakBranches", branch_count, 3);
    checkOutput("streakMisses",   miss_count,   2);
    checkOutput("streakPulses",   pulseCount,   2);
`ifdef BRANCH_DRIVER_STREAK_EN
    checkOutput("maxStreak",      max_streak,   2);
`endif

    $display("[TB] fifo full");
    doReset();
    sawNotReady = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1, 1'($urandom), 1'($urandom), 1);
    drain(0);
    checkOutput("fullReadyDrop", sawNotReady, 1);

    $display("[TB] reset mid-flight");
    doReset();
    applyStimulus(1, 1, 1, 1);
    n = 0;
    while (phase != 2 && n < 10) begin
      applyStimulus(0, 0, 1, 1);
      n++;
    end
    checkOutput("reachWait", phase == 2, 1);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1);
    checkOutput("midResetBusy",  busy,         0);
    checkOutput("midResetCount", branch_count, 0);

    $display("[TB] counter saturation");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 1);
    drain(0);
    checkOutput("satMiss2",   miss_count2,   3);
    checkOutput("satBranch2", branch_count2, 3);
    checkOutput("satMiss16",  miss_count,    5);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 199) != 0);
    end
    drain(1'($urandom));

    @(negedge clk);
    checkAll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
